// File: rtl/pq_shift_array.sv
// Systolic shift-register priority queue.
// Cells c[0..CAPACITY-1] hold <key,value> pairs sorted by ascending key, and
// c[0] (the minimum) is the head. Each cell decides its own next value from
// its neighbours and a few broadcast flags, so every operation takes one cycle.
// Occupancy is tracked by count, never by key value, so KEYINF is a usable key.

package pq_pkg;
  localparam int KEY_WIDTH   = 32;
  localparam int VAL_WIDTH   = 32;
  localparam int PQ_CAPACITY = 16;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  localparam logic [KEY_WIDTH-1:0] KEYINF   = '1;
  localparam kv_t                  KV_EMPTY = '{key: KEYINF, val: '0};
endpackage

// One storage cell. The broadcast "ge" flags say whether a given cell index
// is at or beyond the insert position for the current operation:
//   enqueue : position p = first occupied i with k < c[i].key, else count
//   replace : same search, but cell 0 is excluded (it is being removed)
module pq_cell
  import pq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_op,
  input  kv_t        i_prev,
  input  kv_t        i_next,
  input  kv_t        i_kvi,
  input  logic       i_ge_prev_e,  // cell i-1 is at/after enqueue position
  input  logic       i_ge_self_e,  // this cell is at/after enqueue position
  input  logic       i_ge_self_r,  // this cell is at/after replace position
  input  logic       i_ge_next_r,  // cell i+1 is at/after replace position
  output kv_t        o_c
);
  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_ENQ  = 2'd1;
  localparam logic [1:0] OP_DEQ  = 2'd2;
  localparam logic [1:0] OP_REP  = 2'd3;

  kv_t r_c;

  // Next cell contents: shift toward the tail on enqueue, toward the head on
  // dequeue, and toward the head up to the insert slot on replace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c <= KV_EMPTY;
    end else begin
      case (i_op)
        OP_ENQ: begin
          if (i_ge_prev_e)      r_c <= i_prev;
          else if (i_ge_self_e) r_c <= i_kvi;
        end
        OP_DEQ: r_c <= i_next;
        OP_REP: begin
          if (!i_ge_self_r) r_c <= i_ge_next_r ? i_kvi : i_next;
        end
        default: r_c <= r_c;
      endcase
    end
  end

  assign o_c = r_c;
endmodule

module pq_shift_array
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int CAPACITY  = pq_pkg::PQ_CAPACITY,
  localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  kv_t              kvi,
  input  logic             deq,
  output kv_t              kvo,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             err_ovf,
  output logic             err_udf
);
  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_ENQ  = 2'd1;
  localparam logic [1:0] OP_DEQ  = 2'd2;
  localparam logic [1:0] OP_REP  = 2'd3;

  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_full;
  logic             w_empty;
  logic [1:0]       w_op;
  kv_t              w_c     [CAPACITY+1];   // w_c[CAPACITY] is the virtual empty tail
  kv_t              w_prev  [CAPACITY];
  logic [CAPACITY:0]   w_occ;
  logic [CAPACITY:0]   w_lt;
  logic [CAPACITY-1:0] w_ge_e;
  logic [CAPACITY:0]   w_ge_r;

  assign w_full  = (r_count == CNT_W'(CAPACITY));
  assign w_empty = (r_count == '0);

  // Operation decode. Replace on an empty queue degrades to a plain enqueue;
  // a blocked enqueue or dequeue leaves the cells untouched.
  always_comb begin
    w_op = OP_HOLD;
    if (enq && deq && !w_empty)  w_op = OP_REP;
    else if (enq && !w_full)     w_op = OP_ENQ;
    else if (deq && !enq && !w_empty) w_op = OP_DEQ;
  end

  assign w_c[CAPACITY] = KV_EMPTY;

  // Per-index position flags. Because occupied keys are non-decreasing, the
  // set of occupied cells with k < key is a suffix of the occupied region, so
  // "at or beyond the insert slot" is simply (k < key) or unoccupied.
  for (genvar i = 0; i <= CAPACITY; i++) begin : g_flag
    assign w_occ[i]  = (CNT_W'(i) < r_count);
    assign w_lt[i]   = w_occ[i] && (kvi.key < w_c[i].key);
    assign w_ge_r[i] = ((i >= 1) && w_lt[i]) || !w_occ[i];
  end

  for (genvar i = 0; i < CAPACITY; i++) begin : g_ge_e
    assign w_ge_e[i] = w_lt[i] || !w_occ[i];
  end

  // Cell array: cell 0 has no predecessor, so it can never take a shifted-in
  // pair on enqueue.
  for (genvar i = 0; i < CAPACITY; i++) begin : g_cell
    logic w_ge_prev_e;
    if (i == 0) begin : g_head
      assign w_prev[i]   = KV_EMPTY;
      assign w_ge_prev_e = 1'b0;
    end else begin : g_body
      assign w_prev[i]   = w_c[i-1];
      assign w_ge_prev_e = w_ge_e[i-1];
    end

    pq_cell u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_op       (w_op),
      .i_prev     (w_prev[i]),
      .i_next     (w_c[i+1]),
      .i_kvi      (kvi),
      .i_ge_prev_e(w_ge_prev_e),
      .i_ge_self_e(w_ge_e[i]),
      .i_ge_self_r(w_ge_r[i]),
      .i_ge_next_r(w_ge_r[i+1]),
      .o_c        (w_c[i])
    );
  end

  // Occupancy counter: only a true enqueue or dequeue changes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_ENQ:  r_count <= r_count + CNT_W'(1);
        OP_DEQ:  r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (enq && !deq && w_full)  r_ovf <= 1'b1;
      if (deq && !enq && w_empty) r_udf <= 1'b1;
    end
  end

  assign kvo     = w_c[0];
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  assign err_ovf = r_ovf;
  assign err_udf = r_udf;
endmodule

// File: tb/tb_pq_shift_array.sv
// Self-checking bench for pq_shift_array: a table of directed vectors, a few
// hand-written corner sequences, and a randomized run against a sorted-queue
// reference model.
module tb_pq_shift_array;
  import pq_pkg::*;

  localparam int CAP = 16;
  localparam int CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enq = 1'b0;
  logic          deq = 1'b0;
  kv_t           kvi = KV_EMPTY;
  kv_t           kvo;
  logic          full, empty, err_ovf, err_udf;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  pq_shift_array #(.KEY_WIDTH(32), .VAL_WIDTH(32), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .kvi(kvi), .deq(deq),
    .kvo(kvo), .full(full), .empty(empty), .count(count),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: a queue kept sorted by key, ties in arrival order.
  kv_t m_q[$];
  bit  m_ovf, m_udf;

  task automatic m_insert(input kv_t n);
    int p;
    p = m_q.size();
    for (int i = 0; i < m_q.size(); i++) begin
      if (n.key < m_q[i].key) begin p = i; break; end
    end
    m_q.insert(p, n);
  endtask

  task automatic m_op(input logic e, input logic d, input kv_t n);
    kv_t dummy;
    if (e && d && m_q.size() > 0) begin
      dummy = m_q.pop_front();
      m_insert(n);
    end else if (e) begin
      if (m_q.size() == CAP) begin
        if (!d) m_ovf = 1'b1;
      end else m_insert(n);
    end else if (d) begin
      if (m_q.size() == 0) m_udf = 1'b1;
      else dummy = m_q.pop_front();
    end
  endtask

  // One clocked operation applied to both DUT and model; outputs settle #1 later.
  task automatic step(input logic e, input logic d, input logic [31:0] k, input logic [31:0] v);
    kv_t n;
    n = '{key: k, val: v};
    enq = e; deq = d; kvi = n;
    @(posedge clk); #1;
    enq = 1'b0; deq = 1'b0;
    m_op(e, d, n);
  endtask

  // Synchronous reset with a competing enqueue in the same cycle.
  task automatic do_reset();
    rst_n = 1'b0; enq = 1'b1; deq = 1'b0; kvi = '{key: 32'd3, val: 32'd3};
    @(posedge clk); #1;
    rst_n = 1'b1; enq = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    kv_t h;
    h = (m_q.size() > 0) ? m_q[0] : KV_EMPTY;
    chk({tag, ".kvo"},   64'(kvo),   64'(h));
    chk({tag, ".count"}, 64'(count), 64'(m_q.size()));
    chk({tag, ".full"},  64'(full),  64'(m_q.size() == CAP));
    chk({tag, ".empty"}, 64'(empty), 64'(m_q.size() == 0));
    chk({tag, ".ovf"},   64'(err_ovf), 64'(m_ovf));
    chk({tag, ".udf"},   64'(err_udf), 64'(m_udf));
  endtask

  typedef struct {
    logic        e, d;
    logic [31:0] k, v;
    logic [31:0] xk, xv;
    int          xc;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 32'd40, 32'd140, 32'd40, 32'd140, 1};
    tv[1]  = '{1'b1, 1'b0, 32'd10, 32'd110, 32'd10, 32'd110, 2};
    tv[2]  = '{1'b1, 1'b0, 32'd30, 32'd130, 32'd10, 32'd110, 3};
    tv[3]  = '{1'b1, 1'b0, 32'd20, 32'd120, 32'd10, 32'd110, 4};
    tv[4]  = '{1'b0, 1'b1, 32'd0,  32'd0,   32'd20, 32'd120, 3};
    tv[5]  = '{1'b0, 1'b1, 32'd0,  32'd0,   32'd30, 32'd130, 2};
    tv[6]  = '{1'b0, 1'b1, 32'd0,  32'd0,   32'd40, 32'd140, 1};
    tv[7]  = '{1'b0, 1'b1, 32'd0,  32'd0,   KEYINF, 32'd0,   0};
    tv[8]  = '{1'b1, 1'b0, 32'd5,  32'hA,   32'd5,  32'hA,   1};
    tv[9]  = '{1'b1, 1'b0, 32'd5,  32'hB,   32'd5,  32'hA,   2};
    tv[10] = '{1'b1, 1'b0, 32'd5,  32'hC,   32'd5,  32'hA,   3};
    tv[11] = '{1'b0, 1'b1, 32'd0,  32'd0,   32'd5,  32'hB,   2};
    tv[12] = '{1'b0, 1'b1, 32'd0,  32'd0,   32'd5,  32'hC,   1};
    tv[13] = '{1'b0, 1'b1, 32'd0,  32'd0,   KEYINF, 32'd0,   0};

    // Reset and idle.
    do_reset();
    @(posedge clk); #1;
    chk("rst.kvo",   64'(kvo), 64'(KV_EMPTY));
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full",  64'(full), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.ovf",   64'(err_ovf), 64'd0);
    chk("rst.udf",   64'(err_udf), 64'd0);

    // Directed table: sorting order and FIFO among equal keys.
    for (int i = 0; i < 14; i++) begin
      step(tv[i].e, tv[i].d, tv[i].k, tv[i].v);
      chk($sformatf("tv%0d.key", i), 64'(kvo.key), 64'(tv[i].xk));
      chk($sformatf("tv%0d.val", i), 64'(kvo.val), 64'(tv[i].xv));
      chk($sformatf("tv%0d.cnt", i), 64'(count),   64'(tv[i].xc));
    end

    // Fill to capacity, then overflow and replace-while-full.
    for (int k = 1; k <= CAP; k++) step(1'b1, 1'b0, 32'(k), 32'(k));
    chk("fill.full",  64'(full), 64'd1);
    chk("fill.count", 64'(count), 64'd16);
    step(1'b1, 1'b0, 32'd0, 32'd99);
    chk("ovf.flag",  64'(err_ovf), 64'd1);
    chk("ovf.key",   64'(kvo.key), 64'd1);
    chk("ovf.count", 64'(count), 64'd16);
    step(1'b1, 1'b1, 32'd0, 32'd99);
    chk("repfull.key",   64'(kvo.key), 64'd0);
    chk("repfull.count", 64'(count), 64'd16);
    chk("repfull.full",  64'(full), 64'd1);
    for (int j = 0; j < 15; j++) begin
      step(1'b0, 1'b1, 32'd0, 32'd0);
      chk($sformatf("drain%0d.key", j), 64'(kvo.key), 64'(j + 2));
    end
    step(1'b0, 1'b1, 32'd0, 32'd0);
    chk("drain.empty", 64'(empty), 64'd1);
    chk("drain.ovf_sticky", 64'(err_ovf), 64'd1);
    do_reset();

    // Replace into the middle and to the head.
    step(1'b1, 1'b0, 32'd10, 32'd0);
    step(1'b1, 1'b0, 32'd20, 32'd0);
    step(1'b1, 1'b0, 32'd30, 32'd0);
    step(1'b1, 1'b1, 32'd25, 32'd0);
    chk("rep25.key",   64'(kvo.key), 64'd20);
    chk("rep25.count", 64'(count), 64'd3);
    step(1'b1, 1'b1, 32'd5, 32'd0);
    chk("rep5.key", 64'(kvo.key), 64'd5);
    step(1'b0, 1'b1, 32'd0, 32'd0);
    chk("rep.ord1", 64'(kvo.key), 64'd25);
    step(1'b0, 1'b1, 32'd0, 32'd0);
    chk("rep.ord2", 64'(kvo.key), 64'd30);
    step(1'b0, 1'b1, 32'd0, 32'd0);
    chk("rep.ord3", 64'(kvo), 64'(KV_EMPTY));

    // Replace on empty acts as enqueue; replace with one entry swaps the head.
    step(1'b1, 1'b1, 32'd7, 32'd70);
    chk("repempty.count", 64'(count), 64'd1);
    chk("repempty.udf",   64'(err_udf), 64'd0);
    step(1'b1, 1'b1, 32'd9, 32'd90);
    chk("rep1.kvo",   64'(kvo), {32'd9, 32'd90});
    chk("rep1.count", 64'(count), 64'd1);
    step(1'b0, 1'b1, 32'd0, 32'd0);

    // Underflow, KEYINF as a real key, reset overriding an enqueue.
    step(1'b0, 1'b1, 32'd0, 32'd0);
    chk("udf.flag", 64'(err_udf), 64'd1);
    chk("udf.kvo",  64'(kvo), 64'(KV_EMPTY));
    step(1'b1, 1'b0, KEYINF, 32'd1);
    chk("inf.count", 64'(count), 64'd1);
    chk("inf.empty", 64'(empty), 64'd0);
    chk("inf.key",   64'(kvo.key), 64'(KEYINF));
    do_reset();
    chk("rst2.count", 64'(count), 64'd0);
    chk("rst2.ovf",   64'(err_ovf), 64'd0);
    chk("rst2.udf",   64'(err_udf), 64'd0);
    chk("rst2.kvo",   64'(kvo), 64'(KV_EMPTY));

    // Randomized run against the model, with periodic resets.
    for (int c = 0; c < 3000; c++) begin
      logic e, d;
      logic [31:0] k;
      int r;
      if (c % 600 == 599) begin
        do_reset();
        chk_model("rnd.rst");
        continue;
      end
      r = $urandom_range(0, 99);
      // Drift phases toward full and toward empty to reach both boundaries.
      if ((c / 150) % 2 == 0) begin e = (r < 70); d = (r >= 50); end
      else                     begin e = (r < 35); d = (r >= 20); end
      k = ($urandom_range(0, 19) == 0) ? KEYINF : 32'($urandom_range(0, 15));
      step(e, d, k, $urandom);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pq_shift_array.md
Name: pq_shift_array

Overview:
- Systolic shift-register hardware priority queue; the first concrete HWPQ implementation built on the shared kv_t package types.
- Holds up to CAPACITY <key,value> pairs sorted by ascending key. The head (minimum key) is always visible on kvo.
- Supports enqueue, dequeue, and simultaneous replace in a single cycle each.
- Serves as the baseline implementation that later HWPQ variants are benchmarked against, using the same port interface.

Parameters:
- KEY_WIDTH, 32, key width in bits; must equal pq_pkg::KEY_WIDTH.
- VAL_WIDTH, 32, value width in bits; must equal pq_pkg::VAL_WIDTH.
- CAPACITY, 16 (pq_pkg::PQ_CAPACITY), number of storage cells; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enq  in  1  enqueue request, sampled on the rising edge.
- kvi  in  kv_t  pair to enqueue; valid when enq=1.
- deq  in  1  dequeue request; removes the pair currently shown on kvo.
- kvo  out  kv_t  current head (minimum key); KV_EMPTY when the queue is empty.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- count  out  $clog2(CAPACITY+1)  number of occupied cells.
- err_ovf  out  1  sticky: set by an enqueue while full without a simultaneous deq.
- err_udf  out  1  sticky: set by a dequeue while empty.

Behaviour:
- Storage: cells c[0..CAPACITY-1] of type kv_t, with c[0] as the head.
  - Invariant: occupied cells are contiguous from c[0] and keys are non-decreasing.
  - Unoccupied cells hold KV_EMPTY.
  - Occupancy is tracked by count, never by key value, so KEYINF is a legal user key.
- Reset (rst_n=0 at edge):
  - All cells = KV_EMPTY; count=0; err_ovf=0; err_udf=0.
  - Outputs then read kvo=KV_EMPTY, empty=1, full=0.
  - A reset asserted mid-operation overrides any enq/deq in the same cycle.
- Output timing:
  - kvo = c[0], full, empty and count are all registered-state derived, with no combinational path from inputs.
  - Every operation completes in 1 cycle; its result is visible in the cycle after the edge.
  - Back-to-back operations are accepted every cycle; there is no busy signal.
- Ordering:
  - Compare with unsigned strict less-than: new key k goes ahead of cell i only if k < c[i].key.
  - Equal keys therefore preserve FIFO order (earlier enqueue dequeues first).
- Enqueue only (enq=1, deq=0, not full):
  - Insert position p = first occupied i with kvi.key < c[i].key, else p = count.
  - Cells c[p..count-1] shift to i+1; c[p] = kvi; count+1.
- Enqueue while full (enq=1, deq=0, full=1):
  - No state change; err_ovf set.
  - The pair is dropped; the stored maximum is never evicted.
- Dequeue only (deq=1, enq=0, not empty):
  - c[i] = c[i+1] for i < CAPACITY-1; c[CAPACITY-1] = KV_EMPTY; count-1.
- Dequeue while empty (deq=1, enq=0): no state change; err_udf set.
- Replace (enq=1, deq=1):
  - If not empty: head removed and kvi inserted in the same cycle; count unchanged. Legal when full.
    - Position p = first i ≥ 1 with kvi.key < c[i].key among occupied cells, else p = count.
    - c[0..p-2] = c[1..p-1]; c[p-1] = kvi.
    - If kvi.key < c[1].key (or count==1), kvi becomes the new head.
  - If empty: behaves as enqueue only; err_udf is not set.
- count arithmetic: width $clog2(CAPACITY+1); can never exceed CAPACITY or go below 0 given the rules above.
- Error flags: sticky; cleared only by reset.

Test Plan:
- Reset, then idle → kvo={KEYINF,0}, empty=1, full=0, count=0, err_ovf=0, err_udf=0.
- Enqueue keys 40,10,30,20 (value=key+100) on consecutive cycles, then 4 deqs → kvo sequence after each edge reads 10/110, 20/120, 30/130, 40/140, then KV_EMPTY; count goes 4→0.
- Enqueue {5,A},{5,B},{5,C}, then dequeue 3 times → values come out A, B, C (FIFO among ties).
- Fill with keys 1..16, then enq key 0 with deq=0 → err_ovf=1, contents unchanged (kvo.key=1), count=16. Then enq key 0 with deq=1 → kvo.key=0, count=16, full=1.
- From {10,20,30}, replace with key 25 → kvo.key=20, remaining order 20,25,30, count=3. Then replace with key 5 → kvo.key=5, order 5,25,30.
- deq on empty → err_udf=1, kvo=KV_EMPTY. Then enq key KEYINF → count=1, empty=0, kvo.key=KEYINF. Then assert rst_n=0 together with enq=1 → count=0 and both error flags clear.
